// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: branch funct3 codes,
// controller FSM states and a small source-operand match helper.
package pipe_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_WAIT_MEM = 1'b1
    } hz_state_e;

    function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used & (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath / data memory (master) and the hazard
// controller (slave): stage flags in, stall/flush/redirect and counters out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic              memread_EX;
    logic [4:0]        rd_EX;
    logic [4:0]        rs1_ID;
    logic [4:0]        rs2_ID;
    logic              rs1_used_ID;
    logic              rs2_used_ID;
    logic              memread_MEM;
    logic              memwrite_MEM;
    logic              j_MEM;
    logic              br_MEM;
    logic              EQ_MEM;
    logic              LT_MEM;
    logic              LTU_MEM;
    logic [2:0]        funct3_MEM;
    logic [31:0]       BTA_MEM;
    logic              dmem_ready;

    logic              dmem_req;
    logic              stall_PC;
    logic              stall_IF_ID;
    logic              stall_ID_EX;
    logic              stall_EX_MEM;
    logic              flush_IF_ID;
    logic              flush_ID_EX;
    logic              flush_EX_MEM;
    logic              flush_MEM_WB;
    logic              pc_redirect;
    logic [31:0]       redirect_target;
    logic              mem_err;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output memread_EX, rd_EX, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
               memread_MEM, memwrite_MEM, j_MEM, br_MEM, EQ_MEM, LT_MEM, LTU_MEM,
               funct3_MEM, BTA_MEM, dmem_ready,
        input  dmem_req, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               pc_redirect, redirect_target, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  memread_EX, rd_EX, rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
               memread_MEM, memwrite_MEM, j_MEM, br_MEM, EQ_MEM, LT_MEM, LTU_MEM,
               funct3_MEM, BTA_MEM, dmem_ready,
        output dmem_req, stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               pc_redirect, redirect_target, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/branch_cond_unit.sv
// Evaluates the RV32I conditional-branch predicate from comparator flags.
// Purely combinational; unused funct3 encodings evaluate as not taken.
module branch_cond_unit
    import pipe_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_eq,
    input  logic       i_lt,
    input  logic       i_ltu,
    output logic       o_cond
);

    always_comb begin
        o_cond = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_cond = i_eq;
            F3_BNE:  o_cond = ~i_eq;
            F3_BLT:  o_cond = i_lt;
            F3_BGE:  o_cond = ~i_lt;
            F3_BLTU: o_cond = i_ltu;
            F3_BGEU: o_cond = ~i_ltu;
            default: o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipe: MEM-stage branch redirect,
// load-use bubbles, and a data-memory wait FSM with timeout and perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    hz_state_e          r_state;
    hz_state_e          w_state_nxt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_mem_err;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_mem_op;
    logic               w_timeout;
    logic               w_freeze;
    logic               w_req;
    logic               w_cond;
    logic               w_taken;
    logic               w_lu;
    logic               w_stall_inc;
    logic               w_flush_inc;

    assign w_mem_op  = hz.memread_MEM | hz.memwrite_MEM;
    assign w_timeout = (r_wait_cnt == WAIT_W'(WAIT_MAX));

    branch_cond_unit u_branch_cond (
        .i_funct3 (hz.funct3_MEM),
        .i_eq     (hz.EQ_MEM),
        .i_lt     (hz.LT_MEM),
        .i_ltu    (hz.LTU_MEM),
        .o_cond   (w_cond)
    );

    assign w_taken = hz.j_MEM | (hz.br_MEM & w_cond);
    assign w_lu    = hz.memread_EX & (hz.rd_EX != 5'd0) &
                     (src_hit(hz.rs1_used_ID, hz.rs1_ID, hz.rd_EX) |
                      src_hit(hz.rs2_used_ID, hz.rs2_ID, hz.rd_EX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_freeze    = 1'b0;
        w_req       = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_req = w_mem_op;
                if (w_mem_op && !hz.dmem_ready) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                w_req = 1'b1;
                if (hz.dmem_ready || w_timeout) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_freeze = 1'b1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // A completion arriving on the timeout cycle counts as a real completion, not an error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (r_state == ST_RUN && w_state_nxt == ST_WAIT_MEM) begin
                r_wait_cnt <= WAIT_W'(1);
            end else if (r_state == ST_WAIT_MEM && w_state_nxt == ST_WAIT_MEM) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (r_state == ST_WAIT_MEM && w_timeout && !hz.dmem_ready) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        hz.dmem_req        = 1'b0;
        hz.stall_PC        = 1'b0;
        hz.stall_IF_ID     = 1'b0;
        hz.stall_ID_EX     = 1'b0;
        hz.stall_EX_MEM    = 1'b0;
        hz.flush_IF_ID     = 1'b0;
        hz.flush_ID_EX     = 1'b0;
        hz.flush_EX_MEM    = 1'b0;
        hz.flush_MEM_WB    = 1'b0;
        hz.pc_redirect     = 1'b0;
        hz.redirect_target = 32'd0;
        if (!reset) begin
            hz.dmem_req = w_req;
            if (w_freeze) begin
                hz.stall_PC     = 1'b1;
                hz.stall_IF_ID  = 1'b1;
                hz.stall_ID_EX  = 1'b1;
                hz.stall_EX_MEM = 1'b1;
                hz.flush_MEM_WB = 1'b1;
            end else if (w_taken) begin
                hz.pc_redirect     = 1'b1;
                hz.redirect_target = hz.BTA_MEM;
                hz.flush_IF_ID     = 1'b1;
                hz.flush_ID_EX     = 1'b1;
                hz.flush_EX_MEM    = 1'b1;
            end else if (w_lu) begin
                hz.stall_PC    = 1'b1;
                hz.stall_IF_ID = 1'b1;
                hz.flush_ID_EX = 1'b1;
            end
        end
    end

    assign w_stall_inc = w_freeze | (w_lu & ~w_taken);
    assign w_flush_inc = w_taken & ~w_freeze;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign hz.mem_err   = r_mem_err;
    assign hz.stall_cnt = r_stall_cnt;
    assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued as each step is
// driven and compared when the DUT outputs settle on the following falling edge.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W    = 8;
    localparam int WAIT_MAX = 4;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    typedef struct packed {
        logic [3:0]  stall;
        logic [3:0]  flush;
        logic        redir;
        logic [31:0] tgt;
        logic        req;
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    int checks   = 0;
    int failures = 0;
    int exp_sc   = 0;
    int exp_fc   = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr_inputs();
        hz.memread_EX   = 1'b0;
        hz.rd_EX        = 5'd0;
        hz.rs1_ID       = 5'd0;
        hz.rs2_ID       = 5'd0;
        hz.rs1_used_ID  = 1'b0;
        hz.rs2_used_ID  = 1'b0;
        hz.memread_MEM  = 1'b0;
        hz.memwrite_MEM = 1'b0;
        hz.j_MEM        = 1'b0;
        hz.br_MEM       = 1'b0;
        hz.EQ_MEM       = 1'b0;
        hz.LT_MEM       = 1'b0;
        hz.LTU_MEM      = 1'b0;
        hz.funct3_MEM   = 3'b000;
        hz.BTA_MEM      = 32'd0;
        hz.dmem_ready   = 1'b0;
    endtask

    task automatic compare_out();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            chk({t, ".stall"}, {28'd0, hz.stall_PC, hz.stall_IF_ID, hz.stall_ID_EX, hz.stall_EX_MEM}, {28'd0, e.stall});
            chk({t, ".flush"}, {28'd0, hz.flush_IF_ID, hz.flush_ID_EX, hz.flush_EX_MEM, hz.flush_MEM_WB}, {28'd0, e.flush});
            chk({t, ".redir"}, {31'd0, hz.pc_redirect}, {31'd0, e.redir});
            chk({t, ".target"}, hz.redirect_target, e.tgt);
            chk({t, ".req"}, {31'd0, hz.dmem_req}, {31'd0, e.req});
            chk({t, ".err"}, {31'd0, hz.mem_err}, {31'd0, e.err});
            chk({t, ".stall_cnt"}, {{(32-CNT_W){1'b0}}, hz.stall_cnt}, e.sc);
            chk({t, ".flush_cnt"}, {{(32-CNT_W){1'b0}}, hz.flush_cnt}, e.fc);
        end
    endtask

    // Inputs are already driven; dsc/dfc say whether this cycle should bump the counters.
    task automatic step(input logic [3:0] es, input logic [3:0] ef, input logic er,
                        input logic [31:0] et, input logic ereq,
                        input int dsc, input int dfc, input string tag);
        exp_t e;
        e.stall = es;
        e.flush = ef;
        e.redir = er;
        e.tgt   = et;
        e.req   = ereq;
        e.err   = exp_err;
        e.sc    = exp_sc;
        e.fc    = exp_fc;
        sb.push_back(e);
        sb_tag.push_back(tag);
        @(negedge clk);
        compare_out();
        exp_sc = (exp_sc + dsc > SAT) ? SAT : exp_sc + dsc;
        exp_fc = (exp_fc + dfc > SAT) ? SAT : exp_fc + dfc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        clr_inputs();
        reset = 1'b1;
        hz.memread_MEM = 1'b1;
        #1;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b0, 0, 0, "reset");
        reset = 1'b0;
        clr_inputs();

        // load-use on rs1 and rs2, and the x0 / unused-source exemptions
        hz.memread_EX = 1'b1; hz.rd_EX = 5'd5; hz.rs1_ID = 5'd5; hz.rs1_used_ID = 1'b1;
        step(4'b1100, 4'b0100, 1'b0, 32'd0, 1'b0, 1, 0, "lu_rs1");
        hz.rd_EX = 5'd0; hz.rs1_ID = 5'd0;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b0, 0, 0, "lu_x0");
        hz.rd_EX = 5'd7; hz.rs1_ID = 5'd1; hz.rs2_ID = 5'd7; hz.rs2_used_ID = 1'b1;
        step(4'b1100, 4'b0100, 1'b0, 32'd0, 1'b0, 1, 0, "lu_rs2");
        hz.rs2_used_ID = 1'b0;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b0, 0, 0, "lu_unused");
        clr_inputs();

        // branch resolution
        hz.br_MEM = 1'b1; hz.funct3_MEM = 3'b101; hz.LT_MEM = 1'b0; hz.BTA_MEM = 32'h0000_0040;
        step(4'b0000, 4'b1110, 1'b1, 32'h0000_0040, 1'b0, 0, 1, "bge_taken");
        hz.LT_MEM = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b0, 0, 0, "bge_not");
        hz.funct3_MEM = 3'b010; hz.EQ_MEM = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b0, 0, 0, "f3_010");
        hz.funct3_MEM = 3'b000; hz.BTA_MEM = 32'h1234_5678;
        step(4'b0000, 4'b1110, 1'b1, 32'h1234_5678, 1'b0, 0, 1, "beq_taken");
        hz.funct3_MEM = 3'b110; hz.LTU_MEM = 1'b1; hz.LT_MEM = 1'b0; hz.BTA_MEM = 32'hABCD_0000;
        step(4'b0000, 4'b1110, 1'b1, 32'hABCD_0000, 1'b0, 0, 1, "bltu_taken");
        clr_inputs();

        // jump overrides a concurrent load-use
        hz.j_MEM = 1'b1; hz.BTA_MEM = 32'h0000_0080;
        hz.memread_EX = 1'b1; hz.rd_EX = 5'd9; hz.rs1_ID = 5'd9; hz.rs1_used_ID = 1'b1;
        step(4'b0000, 4'b1110, 1'b1, 32'h0000_0080, 1'b0, 0, 1, "jal_over_lu");
        clr_inputs();

        // three-cycle memory wait
        hz.memread_MEM = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b1111, 4'b0001, 1'b0, 32'd0, 1'b1, 1, 0, "mem_wait");
        hz.dmem_ready = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b1, 0, 0, "mem_done");
        clr_inputs();
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b0, 0, 0, "mem_idle");

        // zero-wait store
        hz.memwrite_MEM = 1'b1; hz.dmem_ready = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b1, 0, 0, "zero_wait");
        clr_inputs();

        // branch and mem op together: freeze first, branch once released
        hz.memwrite_MEM = 1'b1; hz.br_MEM = 1'b1; hz.funct3_MEM = 3'b000; hz.EQ_MEM = 1'b1;
        hz.BTA_MEM = 32'h0000_0100;
        step(4'b1111, 4'b0001, 1'b0, 32'd0, 1'b1, 1, 0, "mix_freeze");
        hz.dmem_ready = 1'b1;
        step(4'b0000, 4'b1110, 1'b1, 32'h0000_0100, 1'b1, 0, 1, "mix_release");
        clr_inputs();

        // timeout: WAIT_MAX=4 gives four frozen cycles, then release and sticky error
        hz.memread_MEM = 1'b1;
        for (int i = 0; i < 4; i++) step(4'b1111, 4'b0001, 1'b0, 32'd0, 1'b1, 1, 0, "to_wait");
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b1, 0, 0, "to_release");
        clr_inputs();
        exp_err = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b0, 0, 0, "to_err1");
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b0, 0, 0, "to_err2");

        // stall counter saturation
        hz.memread_EX = 1'b1; hz.rd_EX = 5'd3; hz.rs1_ID = 5'd3; hz.rs1_used_ID = 1'b1;
        for (int i = 0; i < 250; i++) step(4'b1100, 4'b0100, 1'b0, 32'd0, 1'b0, 1, 0, "sat");
        chk("sat_final", {{(32-CNT_W){1'b0}}, hz.stall_cnt}, SAT);
        clr_inputs();

        // asynchronous reset in the middle of a memory wait
        hz.memread_MEM = 1'b1;
        step(4'b1111, 4'b0001, 1'b0, 32'd0, 1'b1, 1, 0, "rst_wait0");
        step(4'b1111, 4'b0001, 1'b0, 32'd0, 1'b1, 1, 0, "rst_wait1");
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async.req", {31'd0, hz.dmem_req}, 32'd0);
        chk("rst_async.err", {31'd0, hz.mem_err}, 32'd0);
        chk("rst_async.stall_cnt", {{(32-CNT_W){1'b0}}, hz.stall_cnt}, 32'd0);
        chk("rst_async.flush_cnt", {{(32-CNT_W){1'b0}}, hz.flush_cnt}, 32'd0);
        chk("rst_async.stall_PC", {31'd0, hz.stall_PC}, 32'd0);
        exp_sc = 0; exp_fc = 0; exp_err = 1'b0;
        clr_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b0, 0, 0, "post_rst_idle");
        hz.memread_MEM = 1'b1;
        step(4'b1111, 4'b0001, 1'b0, 32'd0, 1'b1, 1, 0, "post_rst_mem");
        hz.dmem_ready = 1'b1;
        step(4'b0000, 4'b0000, 1'b0, 32'd0, 1'b1, 0, 0, "post_rst_done");
        clr_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Resolves branches and jumps in MEM, from the flags and target registered into the EX/MEM register. Drives the PC redirect and squashes the younger stages.
- Inserts load-use bubbles.
- Sequences the data-memory request/ready handshake, freezing the pipeline while memory is busy, with a timeout watchdog and saturating performance counters.

Parameters:
- WAIT_MAX, 255: max cycles in WAIT_MEM before the timeout fires (≥1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- memread_EX  in  1  load in EX
- rd_EX  in  5  EX destination register
- rs1_ID  in  5  ID source register 1
- rs2_ID  in  5  ID source register 2
- rs1_used_ID  in  1  ID reads rs1
- rs2_used_ID  in  1  ID reads rs2
- memread_MEM  in  1  load in MEM
- memwrite_MEM  in  1  store in MEM
- j_MEM  in  1  jump in MEM
- br_MEM  in  1  conditional branch in MEM
- EQ_MEM  in  1  operands equal
- LT_MEM  in  1  signed less-than
- LTU_MEM  in  1  unsigned less-than
- funct3_MEM  in  3  branch type
- BTA_MEM  in  32  branch/jump target
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory request
- stall_PC  out  1  hold PC
- stall_IF_ID  out  1  hold IF/ID
- stall_ID_EX  out  1  hold ID/EX
- stall_EX_MEM  out  1  hold EX/MEM
- flush_IF_ID  out  1  squash IF/ID
- flush_ID_EX  out  1  squash ID/EX
- flush_EX_MEM  out  1  squash EX/MEM
- flush_MEM_WB  out  1  squash MEM/WB
- pc_redirect  out  1  load PC from redirect_target
- redirect_target  out  32  new PC
- mem_err  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  stall cycles
- flush_cnt  out  CNT_W  redirects taken

Behaviour:
- FSM states: RUN, WAIT_MEM. Reset → RUN. Reset also clears: wait counter, mem_err, stall_cnt, flush_cnt. All combinational outputs evaluate to 0 under reset.
- Internal signals:
  - mem_op = memread_MEM | memwrite_MEM
  - freeze = (RUN & mem_op & ~dmem_ready) | (WAIT_MEM & ~dmem_ready & ~timeout)
  - timeout = (wait_cnt == WAIT_MAX)
- dmem_req = mem_op in RUN; 1 in WAIT_MEM. Held high until the cycle dmem_ready is seen.
- Zero-wait access: in RUN with mem_op & dmem_ready, no stall and the FSM stays in RUN.
- RUN → WAIT_MEM when mem_op & ~dmem_ready; wait_cnt ← 1.
- In WAIT_MEM:
  - wait_cnt increments each cycle.
  - dmem_ready → RUN.
  - timeout → RUN with mem_err ← 1 (sticky until reset); the access is abandoned and the pipeline released.
- Branch/jump resolution (combinational from the MEM inputs):
  - taken = j_MEM | (br_MEM & cond).
  - cond by funct3: 000 EQ, 001 ~EQ, 100 LT, 101 ~LT, 110 LTU, 111 ~LTU.
  - funct3 010 and 011 → not taken.
- Load-use hazard: lu = memread_EX & (rd_EX != 0) & ((rs1_used_ID & rs1_ID == rd_EX) | (rs2_used_ID & rs2_ID == rd_EX)).
- Priority, highest first:
  1. freeze:
     - all four stall_* = 1 and flush_MEM_WB = 1
     - all other flushes = 0, pc_redirect = 0
  2. taken:
     - pc_redirect = 1, redirect_target = BTA_MEM
     - flush_IF_ID = flush_ID_EX = flush_EX_MEM = 1, no stalls
     - lu is suppressed because the EX instruction is squashed
  3. lu:
     - stall_PC = stall_IF_ID = 1, flush_ID_EX = 1
     - stall_ID_EX = stall_EX_MEM = 0
- Branch and mem_op are mutually exclusive in MEM (same instruction). If both are asserted, freeze wins and taken is re-evaluated when the freeze releases.
- redirect_target = BTA_MEM whenever pc_redirect is 1; otherwise don't-care, driven 0.
- Counters:
  - stall_cnt += 1 on each cycle with freeze | (lu & ~taken).
  - flush_cnt += 1 on each cycle with taken & ~freeze.
  - Both saturate at all-ones.
- Reset mid-WAIT_MEM: the FSM returns to RUN immediately (asynchronous); dmem_req drops without waiting for dmem_ready.

Decomposition:
- Shared package (pipe_pkg): funct3 branch encodings (BEQ/BNE/BLT/BGE/BLTU/BGEU) and the FSM state enum.
- Sub-module branch_cond_unit: funct3, EQ, LT, LTU → cond. Purely combinational; reused by any future EX-stage resolution.
- Counters and FSM stay in the top.

Test Plan:
1. Load x5 in EX, rs1_ID = 5, rs1_used_ID = 1 → one cycle with stall_PC = stall_IF_ID = flush_ID_EX = 1; stall_cnt 0 → 1. Same stimulus with rd_EX = 0 → no stall.
2. br_MEM = 1, funct3 = 101, LT_MEM = 0, BTA_MEM = 0x0000_0040 → pc_redirect = 1, target 0x40, flushes IF_ID/ID_EX/EX_MEM = 1, flush_cnt = 1. Same stimulus with LT_MEM = 1 → no redirect.
3. memread_MEM = 1, dmem_ready low 3 cycles then high → dmem_req high 4 cycles, stalls + flush_MEM_WB high 3 cycles, FSM back in RUN, stall_cnt += 3.
4. Taken jump in MEM while lu is true → redirect only; no ID_EX stall; stall_cnt unchanged.
5. WAIT_MAX = 4, dmem_ready never asserted → freeze for 4 cycles, then release, mem_err = 1 and stays 1.
6. Assert reset during WAIT_MEM → dmem_req = 0, mem_err = 0, counters = 0 immediately; first post-reset cycle in RUN with no stalls.
